// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// led_pattern_gen : step-rate LED sequencer with 4 patterns, PWM dimming and
//                   selectable output polarity.
// Revision: 1.0
// ============================================================================
module led_pattern_gen #(
   parameter int CLK_HZ         = 27000000,
   parameter int STEP_HZ        = 4,
   parameter int NUM_LEDS       = 6,
   parameter int PWM_BITS       = 4,
   parameter bit LED_ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [NUM_LEDS-1:0] led,
   output logic                step_pulse
);

   localparam int DIV = CLK_HZ / STEP_HZ;
   localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(DIV - 1);
   localparam logic [PRESC_W-1:0]  PRESC_ONE = PRESC_W'(1);
   localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);
   localparam logic [NUM_LEDS-1:0] PAT_ONE   = NUM_LEDS'(1);
   localparam logic [NUM_LEDS-1:0] LED_OFF   = LED_ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

   localparam logic [1:0] MODE_BIN  = 2'b00;
   localparam logic [1:0] MODE_ROT  = 2'b01;
   localparam logic [1:0] MODE_BNC  = 2'b10;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [NUM_LEDS-1:0] pat_q, pat_d;
   dir_t                dir_q, dir_d;
   logic                fill_q, fill_d;
   logic [1:0]          mode_q, mode_d;
   logic                step_pulse_q, step_pulse_d;
   logic [NUM_LEDS-1:0] led_q, led_d;

   logic                reload;
   logic                tick;
   logic                gate;
   logic [NUM_LEDS-1:0] on_mask;
   logic [NUM_LEDS-1:0] seed;
   logic [NUM_LEDS-1:0] pat_step;
   dir_t                dir_step;
   logic                fill_step;

   // Pattern successor for the mode currently in effect.
   always_comb begin
      pat_step  = pat_q;
      dir_step  = dir_q;
      fill_step = fill_q;
      case (mode_q)
         MODE_BIN: pat_step = pat_q + PAT_ONE;
         MODE_ROT: pat_step = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
         MODE_BNC: begin
            if (dir_q == DIR_UP) begin
               pat_step = pat_q << 1;
               if (pat_step[NUM_LEDS-1]) dir_step = DIR_DOWN;
            end else begin
               pat_step = pat_q >> 1;
               if (pat_step[0]) dir_step = DIR_UP;
            end
         end
         default: begin
            pat_step = {pat_q[NUM_LEDS-2:0], fill_q};
            if (&pat_step) begin
               fill_step = 1'b0;
            end else if (~|pat_step) begin
               fill_step = 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      seed = '0;
      if (mode == MODE_ROT || mode == MODE_BNC) seed = PAT_ONE;
   end

   // A mode change reloads state and swallows any step due on the same edge.
   always_comb begin
      reload       = (mode != mode_q);
      tick         = en && (presc_q == PRESC_MAX) && !reload;
      mode_d       = mode;
      presc_d      = presc_q;
      pat_d        = pat_q;
      dir_d        = dir_q;
      fill_d       = fill_q;
      step_pulse_d = tick;
      pwm_d        = pwm_q + PWM_ONE;

      if (reload) begin
         presc_d = '0;
         pat_d   = seed;
         dir_d   = DIR_UP;
         fill_d  = 1'b1;
      end else if (en) begin
         presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
         if (tick) begin
            pat_d  = pat_step;
            dir_d  = dir_step;
            fill_d = fill_step;
         end
      end

      gate    = (&brightness) || (pwm_q < brightness);
      on_mask = pat_q & {NUM_LEDS{gate}};
      led_d   = LED_ACTIVE_LOW ? ~on_mask : on_mask;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         pwm_q        <= '0;
         pat_q        <= '0;
         dir_q        <= DIR_UP;
         fill_q       <= 1'b1;
         mode_q       <= MODE_BIN;
         step_pulse_q <= 1'b0;
         led_q        <= LED_OFF;
      end else begin
         presc_q      <= presc_d;
         pwm_q        <= pwm_d;
         pat_q        <= pat_d;
         dir_q        <= dir_d;
         fill_q       <= fill_d;
         mode_q       <= mode_d;
         step_pulse_q <= step_pulse_d;
         led_q        <= led_d;
      end
   end

   assign led        = led_q;
   assign step_pulse = step_pulse_q;

endmodule
`default_nettype wire
